ps2_ascii_decoder: RTL and testbench

Converts the raw PS/2 scan-code byte stream (scan code set 2, US layout) from the PS/2 byte receiver into ASCII characters, and hands each one to the line-assembly stage as a clean `key_pressed` pulse with a stable `ascii_char`. It tracks make/break prefixes, shift and caps-lock state. It sits between the PS/2 receiver and the 32-character line buffer, which advances its slot on the falling edge of `key_pressed` and captures `ascii_char` on the rising edge.

---
 rtl/ps2_ascii_decoder_if.sv | 19 +
 rtl/ps2_ascii_decoder.sv | 211 +++++++++++++++++++++
 tb/tb_ps2_ascii_decoder.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_ascii_decoder_if.sv
// Byte-stream input and character-strobe output of the PS/2 scan-code to ASCII decoder.
// master = byte producer / line-buffer side, slave = decoder.
interface ps2_ascii_decoder_if;
  logic [7:0] ps2_byte;
  logic       ps2_byte_valid;
  logic [7:0] ascii_char;
  logic       key_pressed;
  logic       dropped;

  modport master (
    output ps2_byte, ps2_byte_valid,
    input  ascii_char, key_pressed, dropped
  );

  modport slave (
    input  ps2_byte, ps2_byte_valid,
    output ascii_char, key_pressed, dropped
  );
endinterface

// File: rtl/ps2_ascii_decoder.sv
// Scan-code set 2 (US) to ASCII decoder: prefix/modifier tracking, a one-entry pending
// buffer and a fixed-length key_pressed pulse with ascii_char held stable around it.
module ps2_ascii_decoder #(
  parameter int PULSE_LEN = 4
) (
  input  logic               clock,
  input  logic               resetn,
  ps2_ascii_decoder_if.slave bus
);

  localparam int CW = $clog2(PULSE_LEN);
  localparam logic [CW-1:0] LAST = CW'(PULSE_LEN - 1);

  typedef enum logic [1:0] {PRE_IDLE, PRE_BRK, PRE_EXT, PRE_EXTBRK} pre_state_t;
  typedef enum logic [1:0] {OUT_IDLE, OUT_SETUP, OUT_HIGH, OUT_GAP} out_state_t;

  pre_state_t pre_state, pre_next;
  out_state_t out_state, out_next;
  logic [CW-1:0] cnt, cnt_next;

  logic       shift_l, shift_r, caps;
  logic       is_make, is_break, is_ext_make;
  logic       dec_valid;
  logic [7:0] dec_char;

  logic [7:0] ascii_q, ascii_d;
  logic       key_q, key_d;
  logic       drop_q, drop_d;
  logic       pend_valid, pend_valid_d;
  logic [7:0] pend_char, pend_char_d;

  // Returns {hit, char} for a plain make code.
  function automatic logic [8:0] map_make(input logic [7:0] code, input logic shift,
                                          input logic caps_on);
    logic [4:0] idx;
    logic       letter;
    logic       hit;
    logic [7:0] ch;
    idx    = '0;
    letter = 1'b1;
    hit    = 1'b1;
    ch     = 8'h00;
    case (code)
      8'h1C: idx = 5'd0;   8'h32: idx = 5'd1;   8'h21: idx = 5'd2;   8'h23: idx = 5'd3;
      8'h24: idx = 5'd4;   8'h2B: idx = 5'd5;   8'h34: idx = 5'd6;   8'h33: idx = 5'd7;
      8'h43: idx = 5'd8;   8'h3B: idx = 5'd9;   8'h42: idx = 5'd10;  8'h4B: idx = 5'd11;
      8'h3A: idx = 5'd12;  8'h31: idx = 5'd13;  8'h44: idx = 5'd14;  8'h4D: idx = 5'd15;
      8'h15: idx = 5'd16;  8'h2D: idx = 5'd17;  8'h1B: idx = 5'd18;  8'h2C: idx = 5'd19;
      8'h3C: idx = 5'd20;  8'h2A: idx = 5'd21;  8'h1D: idx = 5'd22;  8'h22: idx = 5'd23;
      8'h35: idx = 5'd24;  8'h1A: idx = 5'd25;
      default: letter = 1'b0;
    endcase
    if (letter) begin
      ch = ((shift ^ caps_on) ? 8'h41 : 8'h61) + {3'b000, idx};
    end else begin
      // Caps lock deliberately ignored outside the letter block.
      case (code)
        8'h45: ch = shift ? 8'h29 : 8'h30;
        8'h16: ch = shift ? 8'h21 : 8'h31;
        8'h1E: ch = shift ? 8'h40 : 8'h32;
        8'h26: ch = shift ? 8'h23 : 8'h33;
        8'h25: ch = shift ? 8'h24 : 8'h34;
        8'h2E: ch = shift ? 8'h25 : 8'h35;
        8'h36: ch = shift ? 8'h5E : 8'h36;
        8'h3D: ch = shift ? 8'h26 : 8'h37;
        8'h3E: ch = shift ? 8'h2A : 8'h38;
        8'h46: ch = shift ? 8'h28 : 8'h39;
        8'h29: ch = 8'h20;
        8'h5A: ch = 8'h0D;
        8'h66: ch = 8'h08;
        default: hit = 1'b0;
      endcase
    end
    return {hit, ch};
  endfunction

  // ---------------- prefix FSM ----------------
  // NOTE: every register in this block (FSMs, modifiers, pending buffer, outputs) is
  // cleared by the async reset; none of them may come up with a stale character.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) pre_state <= PRE_IDLE;
    else         pre_state <= pre_next;
  end

  // NOTE: defaults at the top of every always_comb keep it free of inferred latches.
  always_comb begin
    pre_next = pre_state;
    if (bus.ps2_byte_valid) begin
      case (pre_state)
        PRE_IDLE: begin
          if      (bus.ps2_byte == 8'hF0) pre_next = PRE_BRK;
          else if (bus.ps2_byte == 8'hE0) pre_next = PRE_EXT;
          else                            pre_next = PRE_IDLE;
        end
        PRE_EXT: pre_next = (bus.ps2_byte == 8'hF0) ? PRE_EXTBRK : PRE_IDLE;
        default: pre_next = PRE_IDLE;
      endcase
    end
  end

  always_comb begin
    is_make     = 1'b0;
    is_break    = 1'b0;
    is_ext_make = 1'b0;
    if (bus.ps2_byte_valid) begin
      case (pre_state)
        PRE_IDLE: is_make     = (bus.ps2_byte != 8'hF0) && (bus.ps2_byte != 8'hE0);
        PRE_BRK:  is_break    = 1'b1;
        PRE_EXT:  is_ext_make = (bus.ps2_byte != 8'hF0);
        default:  ;
      endcase
    end
  end

  // ---------------- modifiers ----------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      shift_l <= 1'b0;
      shift_r <= 1'b0;
      caps    <= 1'b0;
    end else if (is_make) begin
      if (bus.ps2_byte == 8'h12) shift_l <= 1'b1;
      if (bus.ps2_byte == 8'h59) shift_r <= 1'b1;
      if (bus.ps2_byte == 8'h58) caps    <= ~caps;
    end else if (is_break) begin
      if (bus.ps2_byte == 8'h12) shift_l <= 1'b0;
      if (bus.ps2_byte == 8'h59) shift_r <= 1'b0;
    end
  end

  always_comb begin
    dec_valid = 1'b0;
    dec_char  = 8'h00;
    if (is_make) begin
      {dec_valid, dec_char} = map_make(bus.ps2_byte, shift_l | shift_r, caps);
    end else if (is_ext_make && bus.ps2_byte == 8'h5A) begin
      dec_valid = 1'b1;
      dec_char  = 8'h0D;
    end
  end

  // ---------------- output FSM ----------------
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      out_state  <= OUT_IDLE;
      cnt        <= '0;
      ascii_q    <= 8'h00;
      key_q      <= 1'b0;
      drop_q     <= 1'b0;
      pend_valid <= 1'b0;
      pend_char  <= 8'h00;
    end else begin
      out_state  <= out_next;
      cnt        <= cnt_next;
      ascii_q    <= ascii_d;
      key_q      <= key_d;
      drop_q     <= drop_d;
      pend_valid <= pend_valid_d;
      pend_char  <= pend_char_d;
    end
  end

  always_comb begin
    out_next = out_state;
    cnt_next = '0;
    case (out_state)
      OUT_IDLE:  if (pend_valid || dec_valid) out_next = OUT_SETUP;
      OUT_SETUP: out_next = OUT_HIGH;
      OUT_HIGH: begin
        if (cnt == LAST) out_next = OUT_GAP;
        else             cnt_next = cnt + CW'(1);
      end
      default: begin
        if (cnt == LAST) out_next = OUT_IDLE;
        else             cnt_next = cnt + CW'(1);
      end
    endcase
  end

  // ascii_char only loads in OUT_IDLE, so it is frozen through SETUP, HIGH and GAP.
  always_comb begin
    ascii_d      = ascii_q;
    key_d        = (out_next == OUT_HIGH);
    drop_d       = 1'b0;
    pend_valid_d = pend_valid;
    pend_char_d  = pend_char;
    if (out_state == OUT_IDLE) begin
      if (pend_valid) begin
        ascii_d      = pend_char;
        pend_valid_d = dec_valid;
        if (dec_valid) pend_char_d = dec_char;
      end else if (dec_valid) begin
        ascii_d = dec_char;
      end
    end else if (dec_valid) begin
      if (pend_valid) begin
        drop_d = 1'b1;
      end else begin
        pend_valid_d = 1'b1;
        pend_char_d  = dec_char;
      end
    end
  end

  assign bus.ascii_char  = ascii_q;
  assign bus.key_pressed = key_q;
  assign bus.dropped     = drop_q;

endmodule

// File: tb/tb_ps2_ascii_decoder.sv
// Directed bench for ps2_ascii_decoder: a table of byte sequences with expected characters
// plus hand-written sequences for pulse timing, back-to-back strobes, pause codes and reset.
module tb_ps2_ascii_decoder;
  localparam int PULSE_LEN = 4;

  logic clock;
  logic resetn;
  int   cyc;
  int   checks;
  int   failures;

  ps2_ascii_decoder_if bus ();

  ps2_ascii_decoder #(.PULSE_LEN(PULSE_LEN)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- pulse monitor ----------------
  int         rise_q[$];
  logic [7:0] char_q[$];
  int         len_q[$];
  int         drop_cnt;
  int         stable_err;
  int         bad_len;
  logic       prev_key;
  logic [7:0] prev_ascii;
  logic [7:0] hold_char;
  int         hi_len;

  initial begin
    drop_cnt   = 0;
    stable_err = 0;
    bad_len    = 0;
    prev_key   = 1'b0;
    prev_ascii = 8'h00;
    hold_char  = 8'h00;
    hi_len     = 0;
  end

  always @(negedge clock) begin
    if (!resetn) begin
      prev_key = 1'b0;
      hi_len   = 0;
    end else begin
      if (bus.key_pressed && !prev_key) begin
        rise_q.push_back(cyc);
        char_q.push_back(bus.ascii_char);
        if (bus.ascii_char != prev_ascii) stable_err++;
        hold_char = bus.ascii_char;
        hi_len    = 1;
      end else if (bus.key_pressed) begin
        hi_len++;
        if (bus.ascii_char != hold_char) stable_err++;
      end else if (prev_key) begin
        len_q.push_back(hi_len);
        if (hi_len != PULSE_LEN) bad_len++;
      end
      if (bus.dropped) drop_cnt++;
      prev_key = bus.key_pressed;
    end
    prev_ascii = bus.ascii_char;
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  int last_t;

  // Caller sits 1 time unit after a rising edge; consecutive calls strobe consecutive cycles.
  task automatic strobe(input logic [7:0] b);
    bus.ps2_byte       = b;
    bus.ps2_byte_valid = 1'b1;
    last_t             = cyc;
    @(posedge clock);
    #1;
    bus.ps2_byte_valid = 1'b0;
  endtask

  task automatic clear_capture();
    rise_q.delete();
    char_q.delete();
    len_q.delete();
    drop_cnt = 0;
  endtask

  typedef struct {
    logic [7:0] b [4];
    int         n;
    bit         emit;
    logic [7:0] ch;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int n, input logic [7:0] b0, input logic [7:0] b1,
                     input logic [7:0] b2, input bit emit, input logic [7:0] ch);
    vec_t v;
    v.b[0] = b0;
    v.b[1] = b1;
    v.b[2] = b2;
    v.b[3] = 8'h00;
    v.n    = n;
    v.emit = emit;
    v.ch   = ch;
    vecs.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- test ----------------
  initial begin
    int t0;
    int seen;
    checks   = 0;
    failures = 0;

    // Modifier state carries across rows; comments give the state after each row.
    add(1, 8'h12, 8'h00, 8'h00, 0, 8'h00);  // shift_l
    add(1, 8'h1C, 8'h00, 8'h00, 1, 8'h41);
    add(2, 8'hF0, 8'h12, 8'h00, 0, 8'h00);  // no shift
    add(1, 8'h1C, 8'h00, 8'h00, 1, 8'h61);
    add(1, 8'h58, 8'h00, 8'h00, 0, 8'h00);  // caps on
    add(2, 8'hF0, 8'h58, 8'h00, 0, 8'h00);  // break leaves caps on
    add(1, 8'h1C, 8'h00, 8'h00, 1, 8'h41);
    add(1, 8'h2E, 8'h00, 8'h00, 1, 8'h35);  // caps ignored on digits
    add(1, 8'h12, 8'h00, 8'h00, 0, 8'h00);  // shift + caps
    add(1, 8'h1C, 8'h00, 8'h00, 1, 8'h61);
    add(1, 8'h16, 8'h00, 8'h00, 1, 8'h21);
    add(2, 8'hF0, 8'h12, 8'h00, 0, 8'h00);
    add(1, 8'h58, 8'h00, 8'h00, 0, 8'h00);  // caps off
    add(1, 8'h1A, 8'h00, 8'h00, 1, 8'h7A);
    add(2, 8'hE0, 8'h5A, 8'h00, 1, 8'h0D);
    add(2, 8'hE0, 8'h75, 8'h00, 0, 8'h00);
    add(3, 8'hE0, 8'hF0, 8'h75, 0, 8'h00);
    add(3, 8'hE0, 8'hF0, 8'h5A, 0, 8'h00);
    add(1, 8'h45, 8'h00, 8'h00, 1, 8'h30);
    add(1, 8'h29, 8'h00, 8'h00, 1, 8'h20);
    add(1, 8'h66, 8'h00, 8'h00, 1, 8'h08);
    add(1, 8'h5A, 8'h00, 8'h00, 1, 8'h0D);
    add(1, 8'h59, 8'h00, 8'h00, 0, 8'h00);  // shift_r
    add(1, 8'h45, 8'h00, 8'h00, 1, 8'h29);
    add(1, 8'h3E, 8'h00, 8'h00, 1, 8'h2A);
    add(1, 8'h4D, 8'h00, 8'h00, 1, 8'h50);
    add(2, 8'hF0, 8'h59, 8'h00, 0, 8'h00);
    add(1, 8'h4D, 8'h00, 8'h00, 1, 8'h70);

    bus.ps2_byte       = 8'h00;
    bus.ps2_byte_valid = 1'b0;
    resetn             = 1'b0;
    idle(3);
    check("reset_ascii",   int'(bus.ascii_char),  8'h00);
    check("reset_key",     int'(bus.key_pressed), 0);
    check("reset_dropped", int'(bus.dropped),     0);
    resetn = 1'b1;
    idle(2);

    // Basic make/break and pulse timing.
    clear_capture();
    strobe(8'h1C);
    t0 = last_t;
    check("a_ascii_t1", int'(bus.ascii_char), 8'h61);
    idle(12);
    check("a_pulses", rise_q.size(), 1);
    if (rise_q.size() > 0) check("a_rise_offset", rise_q[0] - t0, 2);
    if (len_q.size() > 0)  check("a_high_len", len_q[0], PULSE_LEN);
    if (char_q.size() > 0) check("a_char", int'(char_q[0]), 8'h61);
    clear_capture();
    strobe(8'hF0);
    idle(12);
    strobe(8'h1C);
    idle(12);
    check("a_break_pulses", rise_q.size(), 0);

    // Table of spaced byte sequences.
    foreach (vecs[i]) begin
      clear_capture();
      for (int j = 0; j < vecs[i].n; j++) begin
        strobe(vecs[i].b[j]);
        idle(12);
      end
      check($sformatf("vec%0d_pulses", i), rise_q.size(), vecs[i].emit ? 1 : 0);
      if (vecs[i].emit && char_q.size() > 0)
        check($sformatf("vec%0d_char", i), int'(char_q[0]), int'(vecs[i].ch));
    end

    // Modifier updates seen by the very next strobe.
    clear_capture();
    strobe(8'h12);
    strobe(8'h1C);
    strobe(8'hF0);
    strobe(8'h12);
    idle(12);
    strobe(8'h1C);
    idle(14);
    check("mod_pulses", rise_q.size(), 2);
    if (char_q.size() > 1) begin
      check("mod_char0", int'(char_q[0]), 8'h41);
      check("mod_char1", int'(char_q[1]), 8'h61);
    end
    check("mod_dropped", drop_cnt, 0);

    // Back-to-back strobes: one pends, one drops.
    clear_capture();
    strobe(8'h1C);
    strobe(8'h32);
    strobe(8'h21);
    idle(30);
    check("b2b_pulses", rise_q.size(), 2);
    if (char_q.size() > 1) begin
      check("b2b_char0", int'(char_q[0]), 8'h61);
      check("b2b_char1", int'(char_q[1]), 8'h62);
      check("b2b_spacing_ok", int'((rise_q[1] - rise_q[0]) >= 2 * PULSE_LEN + 1), 1);
    end
    check("b2b_dropped", drop_cnt, 1);

    // Unmapped code and the pause sequence.
    clear_capture();
    strobe(8'h05); idle(3);
    strobe(8'hE1); idle(3);
    strobe(8'h14); idle(3);
    strobe(8'h77); idle(3);
    strobe(8'hE1); idle(3);
    strobe(8'hF0); idle(3);
    strobe(8'h14); idle(3);
    strobe(8'hF0); idle(3);
    strobe(8'h77); idle(12);
    check("pause_pulses",  rise_q.size(), 0);
    check("pause_dropped", drop_cnt, 0);
    strobe(8'h29);
    idle(12);
    check("pause_space_pulses", rise_q.size(), 1);
    if (char_q.size() > 0) check("pause_space_char", int'(char_q[0]), 8'h20);

    // Reset during the second high cycle with a char pending.
    clear_capture();
    strobe(8'h1C);
    strobe(8'h32);
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (bus.key_pressed) seen = 1;
      else idle(1);
    end
    check("rst_pulse_seen", seen, 1);
    idle(1);
    #1;
    resetn = 1'b0;
    #1;
    check("rst_key_async",   int'(bus.key_pressed), 0);
    check("rst_ascii_async", int'(bus.ascii_char),  8'h00);
    idle(2);
    resetn = 1'b1;
    clear_capture();
    idle(30);
    check("rst_no_pending", rise_q.size(), 0);

    check("ascii_stable", stable_err, 0);
    check("pulse_lengths", bad_len, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
